// File: rtl/hpm_snapshot_sequencer.sv
// HPM snapshot sequencer: periodic capture of hpm counters, streamed as 12-beat packets.
// Define HPM_SEQ_DROP_CNT_EN to build the saturating drop counter.
module hpm_snapshot_sequencer #(
    parameter int unsigned SAMPLE_PERIOD = 1024,
    parameter int unsigned PKT_W         = 32
) (
    input  logic              clk_h,
    input  logic              rst_h,
    input  logic              csr_we,
    input  logic [11:0]       csr_add,
    input  logic [31:0]       csr_data,
    input  logic [11:0][63:0] hpm_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_data,
    output logic [3:0]        out_idx,
    output logic              out_last,
    output logic              armed,
    output logic              overrun,
    output logic [15:0]       drop_cnt
);
    localparam logic [15:0] TMAX = 16'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, STREAM} state_t;

    state_t            state_q, state_d;
    logic [15:0]       tmr_q;
    logic [PKT_W-1:0]  cyc_q, cyc_sh, pkt_q;
    logic [3:0]        idx_q;
    logic              fin_q, fin_nx, ovr_q;
    logic [10:0][63:0] sh_q;
    logic [11:0][63:0] beat;
    logic              start, stop, expire;
    logic              fire, last_fire, drop_ev;
    logic              unused_hpm1;

    assign start = csr_we && csr_add == 12'h320
                   && csr_data == 32'h0000_0000;
    assign stop  = csr_we && csr_add == 12'h320
                   && csr_data == 32'hFFFF_FFFF;

    assign expire    = tmr_q == TMAX;
    assign fire      = out_valid && out_ready;
    assign last_fire = fire && idx_q == 4'd11;
    assign fin_nx    = fin_q | (stop && state_q != IDLE);
    assign drop_ev   = state_q == STREAM && expire && !fin_q;

    // Beat 0 is the header; beats 1..11 are the shadowed counters.
    assign beat[0]    = 64'({pkt_q, cyc_sh});
    assign beat[11:1] = sh_q;

    assign out_valid = state_q == STREAM;
    assign out_idx   = idx_q;
    assign out_last  = out_valid && idx_q == 4'd11;
    assign out_data  = out_valid ? beat[idx_q] : 64'h0;
    assign armed     = state_q != IDLE && !fin_q;
    assign overrun   = ovr_q;

    assign unused_hpm1 = ^hpm_i[1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ARMED;
            ARMED:   if (expire || stop) state_d = CAPTURE;
            CAPTURE: state_d = STREAM;
            STREAM:  if (last_fire) state_d = fin_nx ? IDLE : ARMED;
        endcase
    end

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cyc_q   <= '0;
            cyc_sh  <= '0;
            pkt_q   <= '0;
            idx_q   <= '0;
            fin_q   <= 1'b0;
            ovr_q   <= 1'b0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (start) begin
                    tmr_q <= '0;
                    cyc_q <= '0;
                    pkt_q <= '0;
                    ovr_q <= 1'b0;
                    fin_q <= 1'b0;
                end
            end else begin
                tmr_q <= expire ? 16'd0 : tmr_q + 16'd1;
                cyc_q <= cyc_q + PKT_W'(1);
                fin_q <= fin_nx;
                if (drop_ev) ovr_q <= 1'b1;
                if (state_q == CAPTURE) begin
                    cyc_sh  <= cyc_q;
                    sh_q[0] <= hpm_i[0];
                    for (int k = 2; k < 12; k++) sh_q[k-1] <= hpm_i[k];
                end
                if (fire) idx_q <= last_fire ? 4'd0 : idx_q + 4'd1;
                if (last_fire) begin
                    pkt_q <= pkt_q + PKT_W'(1);
                    if (fin_nx) fin_q <= 1'b0;
                end
            end
        end
    end

`ifdef HPM_SEQ_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            drop_q <= '0;
        end else if (state_q == IDLE && start) begin
            drop_q <= '0;
        end else if (drop_ev && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hpm_snapshot_sequencer.sv
// Randomized scenario bench for hpm_snapshot_sequencer with a
// queue-based packet model; SAMPLE_PERIOD=16.
module tb_hpm_snapshot_sequencer;
    localparam int P = 16;

    logic              clk_h = 1'b0;
    logic              rst_h = 1'b1;
    logic              csr_we = 1'b0;
    logic [11:0]       csr_add = '0;
    logic [31:0]       csr_data = '0;
    logic [11:0][63:0] hpm_i = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [63:0]       out_data;
    logic [3:0]        out_idx;
    logic              out_last;
    logic              armed;
    logic              overrun;
    logic [15:0]       drop_cnt;

    int vectors = 0;
    int fails = 0;

    hpm_snapshot_sequencer #(.SAMPLE_PERIOD(P), .PKT_W(32)) dut (
        .clk_h(clk_h), .rst_h(rst_h), .csr_we(csr_we),
        .csr_add(csr_add), .csr_data(csr_data), .hpm_i(hpm_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .armed(armed), .overrun(overrun), .drop_cnt(drop_cnt)
    );

    always #5 clk_h = ~clk_h;

    // Reference model: tracing window, pending capture, queue of beats.
    bit          m_act = 0, m_fin = 0, m_cap = 0, m_ovr = 0;
    int          m_tmr = 0, m_drops = 0;
    logic [31:0] m_cyc = 0, m_pkt = 0;
    logic [63:0] m_q[$];

    always @(posedge clk_h) begin
        bit st, sp, ex, strm;
        st = csr_we && csr_add == 12'h320 && csr_data == 32'h0;
        sp = csr_we && csr_add == 12'h320 && csr_data == 32'hFFFF_FFFF;
        if (rst_h) begin
            m_act = 0; m_fin = 0; m_cap = 0; m_ovr = 0;
            m_tmr = 0; m_drops = 0; m_cyc = 0; m_pkt = 0;
            m_q.delete();
        end else if (!m_act) begin
            if (st) begin
                m_act = 1; m_fin = 0; m_tmr = 0; m_cyc = 0;
                m_pkt = 0; m_ovr = 0; m_drops = 0;
            end
        end else begin
            ex = m_tmr == P - 1;
            strm = m_q.size() > 0;
            if (strm && ex && !m_fin) begin
                m_ovr = 1;
                m_drops++;
            end
            m_tmr = ex ? 0 : m_tmr + 1;
            if (m_cap) begin
                m_q.push_back({m_pkt, m_cyc});
                m_q.push_back(hpm_i[0]);
                for (int k = 2; k < 12; k++) m_q.push_back(hpm_i[k]);
                m_cap = 0;
            end else if (strm) begin
                if (out_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_pkt++;
                end
            end else if (ex || sp) begin
                m_cap = 1;
            end
            if (sp) m_fin = 1;
            if (strm && m_q.size() == 0 && m_fin) begin
                m_act = 0;
                m_fin = 0;
            end
            m_cyc++;
        end
    end

    logic [87:0] obs;
    assign obs = {out_valid, out_last, out_idx, out_data,
                  armed, overrun, drop_cnt};

    function automatic logic [87:0] expv();
        logic        v;
        logic [15:0] d;
        v = m_q.size() > 0;
`ifdef HPM_SEQ_DROP_CNT_EN
        d = m_drops > 65535 ? 16'hFFFF : 16'(m_drops);
`else
        d = 16'h0;
`endif
        return {v, v && m_q.size() == 1,
                v ? 4'(12 - m_q.size()) : 4'd0,
                v ? m_q[0] : 64'h0,
                m_act && !m_fin, m_ovr, d};
    endfunction

`ifdef HPM_SEQ_DROP_CNT_EN
    localparam logic [15:0] OVR_DROPS = 16'd2;
`else
    localparam logic [15:0] OVR_DROPS = 16'd0;
`endif

    task automatic tick();
        @(posedge clk_h);
        @(negedge clk_h);
        csr_we   = 1'b0;
        csr_add  = 12'($urandom);
        csr_data = $urandom;
        for (int k = 0; k < 12; k++) hpm_i[k] = {$urandom, $urandom};
    endtask

    task automatic wr(input logic [31:0] d);
        csr_we = 1'b1;
        csr_add = 12'h320;
        csr_data = d;
        tick();
    endtask

    task automatic do_reset();
        rst_h = 1'b1;
        tick();
        tick();
        rst_h = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [87:0] e;
        do_reset();
        e = expv();
        vectors++;
        if (obs !== 88'h0 || e !== 88'h0)
            begin fails++; $display("FAIL reset obs=%h exp=0", obs); end
        wr(32'hFFFF_FFFF);
        tick();
        vectors++;
        if (armed !== 1'b0 || out_valid !== 1'b0)
            begin fails++; $display("FAIL stop_idle armed=%b exp=0", armed); end
    endtask

    task automatic test_periodic();
        logic [87:0] e;
        int n;
        do_reset();
        wr(32'h0);
        n = 0;
        while (!out_valid && n < 40) begin
            e = expv(); vectors++;
            if (obs !== e) begin fails++; $display("FAIL periodic obs=%h exp=%h", obs, e); end
            tick(); n++;
        end
        vectors++;
        if (n !== 17) begin fails++; $display("FAIL periodic_latency got=%0d exp=17", n); end
        for (int i = 0; i < 12; i++) begin
            e = expv(); vectors++;
            if (obs !== e) begin fails++; $display("FAIL periodic_beat obs=%h exp=%h", obs, e); end
            vectors++;
            if (out_valid !== 1'b1 || out_idx !== 4'(i) || out_last !== (i == 11))
                begin fails++; $display("FAIL periodic_idx got=%0d exp=%0d", out_idx, i); end
            if (i == 0) begin
                vectors++;
                if (out_data !== {32'd0, 32'd16})
                    begin fails++; $display("FAIL header0 got=%h exp=%h", out_data, {32'd0, 32'd16}); end
            end
            tick();
        end
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        vectors++;
        if (out_data !== {32'd1, 32'd32})
            begin fails++; $display("FAIL header1 got=%h exp=%h", out_data, {32'd1, 32'd32}); end
    endtask

    task automatic test_backpressure();
        logic [87:0] e;
        logic [68:0] prev;
        bit pstall;
        int xi, k;
        do_reset();
        wr(32'h0);
        xi = 0; k = 0; pstall = 0; prev = '0;
        while (xi < 12 && k < 120) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            e = expv(); vectors++;
            if (obs !== e) begin fails++; $display("FAIL bp obs=%h exp=%h", obs, e); end
            if (pstall) begin
                vectors++;
                if ({out_data, out_idx, out_last} !== prev)
                    begin fails++; $display("FAIL bp_stable got=%h exp=%h", {out_data, out_idx, out_last}, prev); end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (out_idx !== 4'(xi))
                    begin fails++; $display("FAIL bp_order got=%0d exp=%0d", out_idx, xi); end
                xi++;
            end
            pstall = out_valid && !out_ready;
            prev = {out_data, out_idx, out_last};
            tick(); k++;
        end
        vectors++;
        if (xi !== 12) begin fails++; $display("FAIL bp_count got=%0d exp=12", xi); end
    endtask

    task automatic test_overrun();
        logic [87:0] e;
        int n;
        do_reset();
        out_ready = 1'b0;
        wr(32'h0);
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        for (int i = 0; i < 40; i++) begin
            e = expv(); vectors++;
            if (obs !== e) begin fails++; $display("FAIL ovr_stall obs=%h exp=%h", obs, e); end
            tick();
        end
        vectors++;
        if (overrun !== 1'b1 || drop_cnt !== OVR_DROPS)
            begin fails++; $display("FAIL ovr_flag got=%b/%0d exp=1/%0d", overrun, drop_cnt, OVR_DROPS); end
        vectors++;
        if (out_data !== {32'd0, 32'd16})
            begin fails++; $display("FAIL ovr_header got=%h exp=%h", out_data, {32'd0, 32'd16}); end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            e = expv(); vectors++;
            if (obs !== e || out_idx !== 4'(i))
                begin fails++; $display("FAIL ovr_beat obs=%h exp=%h", obs, e); end
            tick();
        end
    endtask

    task automatic test_stop_armed();
        logic [87:0] e;
        int pk;
        do_reset();
        wr(32'h0);
        tick(); tick();
        wr(32'h0);
        tick(); tick();
        wr(32'hFFFF_FFFF);
        pk = 0;
        for (int i = 0; i < 90; i++) begin
            out_ready = $urandom_range(0, 3) != 0;
            e = expv(); vectors++;
            if (obs !== e) begin fails++; $display("FAIL stop_armed obs=%h exp=%h", obs, e); end
            if (out_valid && out_ready && out_last) pk++;
            tick();
        end
        vectors++;
        if (pk !== 1 || armed !== 1'b0 || out_valid !== 1'b0)
            begin fails++; $display("FAIL stop_armed_end pkts=%0d armed=%b exp=1/0", pk, armed); end
    endtask

    task automatic test_stop_stream();
        logic [87:0] e;
        int n, beats;
        do_reset();
        wr(32'h0);
        n = 0;
        while (!(out_valid && out_idx == 4'd4) && n < 60) begin tick(); n++; end
        vectors++;
        if (n >= 60) begin fails++; $display("FAIL stop_stream_wait got=%0d exp<60", n); end
        wr(32'hFFFF_FFFF);
        beats = 0;
        for (int i = 0; i < 40; i++) begin
            e = expv(); vectors++;
            if (obs !== e) begin fails++; $display("FAIL stop_stream obs=%h exp=%h", obs, e); end
            if (out_valid && out_ready) beats++;
            tick();
        end
        vectors++;
        if (beats !== 7 || armed !== 1'b0)
            begin fails++; $display("FAIL stop_stream_end beats=%0d armed=%b exp=7/0", beats, armed); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        wr(32'h0);
        n = 0;
        while (!(out_valid && out_last) && n < 60) begin tick(); n++; end
        tick();
        n = 0;
        while (!(out_valid && out_idx == 4'd6) && n < 60) begin tick(); n++; end
        vectors++;
        if (out_data === 64'h0 || n >= 60)
            begin fails++; $display("FAIL rst_mid_wait got=%0d exp<60", n); end
        rst_h = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || armed !== 1'b0)
            begin fails++; $display("FAIL rst_mid valid=%b armed=%b exp=0/0", out_valid, armed); end
        rst_h = 1'b0;
        wr(32'h0);
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        vectors++;
        if (out_data[63:32] !== 32'd0)
            begin fails++; $display("FAIL rst_mid_pkt got=%0d exp=0", out_data[63:32]); end
    endtask

    task automatic test_random();
        logic [87:0] e;
        int r;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            out_ready = $urandom_range(0, 3) != 0;
            rst_h = $urandom_range(0, 599) == 0;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                csr_we = 1'b1; csr_add = 12'h320; csr_data = 32'h0;
            end else if (r < 4) begin
                csr_we = 1'b1; csr_add = 12'h320; csr_data = 32'hFFFF_FFFF;
            end else if (r < 8) begin
                csr_we = 1'b1;
                csr_add = (r < 6) ? 12'h320 : 12'($urandom);
                csr_data = $urandom;
            end
            e = expv(); vectors++;
            if (obs !== e) begin fails++; $display("FAIL random obs=%h exp=%h", obs, e); end
            tick();
        end
        rst_h = 1'b0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_backpressure();
        test_overrun();
        test_stop_armed();
        test_stop_stream();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
